// File: rtl/router_pkg.sv
// Shared constants and types for the router scheduler.
// The stats counter width is used only when ROUTER_SCHED_STATS_EN is defined.
package router_pkg;

    localparam int NUM_PORTS = 4;
    localparam int ADDR_W    = 2;
    localparam int STAT_W    = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/router_sched_rr_pick.sv
// Round-robin winner selection (combinational only).
// The search starts at ptr_i and moves upward, wrapping mod NUM_PORTS.
// The first requester found wins. Both outputs are zero when nothing is requesting.
module rr_pick
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [ADDR_W-1:0]    ptr_i,
    output logic [NUM_PORTS-1:0] win_o,
    output logic [ADDR_W-1:0]    idx_o
);

    logic              found;
    logic [ADDR_W-1:0] cand;

    // Scan from the pointer and take the first active request.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = ptr_i + ADDR_W'(k);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/router_sched.sv
// Four-requester burst scheduler that feeds a single router input port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; pick a round-robin winner if any requester is valid
// ST_LOCK | grant held by one requester until its last beat or MAX_BURST
//
// Each accepted beat appears one cycle later on din/addr with din_en high.
// When ROUTER_SCHED_STATS_EN is defined, the block also keeps saturating
// per-destination beat counters, exposed as stat_cnt and cleared by stat_clr.
module router_sched
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                req_valid,
    output logic [3:0]                req_ready,
    input  logic [4*DATA_WIDTH-1:0]   req_data,
    input  logic [7:0]                req_addr,
    input  logic [3:0]                req_last,
    output logic [DATA_WIDTH-1:0]     din,
    output logic                      din_en,
    output logic [1:0]                addr,
    output logic [3:0]                grant
`ifdef ROUTER_SCHED_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [4*STAT_W-1:0]       stat_cnt
`endif
);

    state_e                  state_q, state_d;
    logic [NUM_PORTS-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    din_en_q, din_en_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;

    logic [NUM_PORTS-1:0]    pick_win;
    logic [ADDR_W-1:0]       pick_idx;
    logic                    xfer;
    logic                    tenure_end;

    rr_pick u_rr_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    // Ready follows the registered grant, so it never depends on this cycle's valid.
    assign req_ready  = (state_q == ST_LOCK) ? grant_q : '0;
    assign xfer       = (state_q == ST_LOCK) && req_valid[idx_q];
    assign tenure_end = xfer && (req_last[idx_q] || (cnt_q == 4'(MAX_BURST - 1)));

    // Next-state logic: arbitration in IDLE, beat capture and release in LOCK.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        din_en_d = 1'b0;
        din_d    = '0;
        addr_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    state_d = ST_LOCK;
                    grant_d = pick_win;
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    din_en_d = 1'b1;
                    din_d    = req_data[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
                    addr_d   = req_addr[int'(idx_q)*ADDR_W +: ADDR_W];
                    cnt_d    = cnt_q + 4'd1;
                    if (tenure_end) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        ptr_d   = idx_q + ADDR_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers. A synchronous reset drops any tenure in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            din_q    <= '0;
            din_en_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            din_q    <= din_d;
            din_en_q <= din_en_d;
            addr_q   <= addr_d;
        end
    end

    assign grant  = grant_q;
    assign din    = din_q;
    assign din_en = din_en_q;
    assign addr   = addr_q;

`ifdef ROUTER_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_PORTS];

    // Per-destination counters of emitted beats. They saturate at all-ones.
    // A clear takes priority over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            for (int i = 0; i < NUM_PORTS; i++) stat_q[i] <= '0;
        end else if (din_en_q && (stat_q[addr_q] != '1)) begin
            stat_q[addr_q] <= stat_q[addr_q] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule
